ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_pkg.sv | 19 +
 rtl/ex_mem_skid.sv | 39 +++
 rtl/ex_mem_stage.sv | 90 +++++++++
 tb/tb_ex_mem_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: op codes, overflow cause, FSM states and the EX/MEM entry type
package ex_mem_pkg;
  localparam logic [4:0] ALU_ADD_S = 5'b10000;
  localparam logic [4:0] ALU_SUB_S = 5'b10010;
  localparam logic [4:0] EXC_OV = 5'd12;
  typedef enum logic {RUN, TRAP} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        zero;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        mem_wr;
    logic [31:0] store_data;
  } entry_t;
  function automatic logic is_ov_op(input logic [4:0] op);
    return op == ALU_ADD_S || op == ALU_SUB_S;
  endfunction
endpackage

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: in-order entry buffer, depth 1 (combinational ready) or 2 (registered ready)
module ex_mem_skid
  import ex_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  entry_t din,
  output logic   ready,
  output logic   out_valid,
  output entry_t dout,
  input  logic   out_ready
);
  logic   sk_v;
  entry_t sk_d;
  assign ready = (DEPTH == 2) ? !sk_v : (!out_valid || out_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      sk_v      <= 1'b0;
      sk_d      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      sk_v      <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= sk_v || push;
      if (sk_v) dout <= sk_d;
      else if (push) dout <= din;
      sk_v <= 1'b0;
    end else if (push) begin
      sk_v <= 1'b1;
      sk_d <= din;
    end
  end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM register with overflow trap FSM; define EX_MEM_SKID_EN for a 2-entry skid buffer
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter logic [4:0] EXC_CODE_OV = 5'd12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_result,
  input  logic        in_zero,
  input  logic        in_overflow,
  input  logic [4:0]  in_op,
  input  logic        in_wb_en,
  input  logic [4:0]  in_wb_addr,
  input  logic        in_mem_wr,
  input  logic [31:0] in_store_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_wb_en,
  output logic [4:0]  out_wb_addr,
  output logic        out_mem_wr,
  output logic [31:0] out_store_data,
  input  logic        out_ready,
  output logic        exc_valid,
  output logic [31:0] exc_epc,
  output logic [4:0]  exc_code
);
`ifdef EX_MEM_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  state_t state, state_nx;
  logic   buf_ready, push, trap;
  entry_t din, dout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else state <= state_nx;
  end
  always_comb state_nx = flush ? RUN : trap ? TRAP : state;
  always_comb in_ready = (state == TRAP) || buf_ready;
  assign push = in_valid && in_ready && state == RUN && !flush;
  assign trap = push && in_overflow && is_ov_op(in_op);
  always_comb begin
    din.pc         = in_pc;
    din.result     = in_result;
    din.zero       = in_zero;
    din.wb_en      = in_wb_en && !trap;
    din.wb_addr    = in_wb_addr;
    din.mem_wr     = in_mem_wr && !trap;
    din.store_data = in_store_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_valid <= 1'b0;
      exc_epc   <= '0;
      exc_code  <= '0;
    end else begin
      exc_valid <= trap;
      if (trap) begin
        exc_epc  <= in_pc;
        exc_code <= EXC_CODE_OV;
      end
    end
  end
  ex_mem_skid #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .din      (din),
    .ready    (buf_ready),
    .out_valid(out_valid),
    .dout     (dout),
    .out_ready(out_ready)
  );
  assign out_pc         = dout.pc;
  assign out_result     = dout.result;
  assign out_zero       = dout.zero;
  assign out_wb_en      = dout.wb_en;
  assign out_wb_addr    = dout.wb_addr;
  assign out_mem_wr     = dout.mem_wr;
  assign out_store_data = dout.store_data;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for ex_mem_stage against a queue-based reference model
module tb_ex_mem_stage;
  import ex_mem_pkg::*;
`ifdef EX_MEM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 0, in_zero = 0, in_overflow = 0, in_wb_en = 0, in_mem_wr = 0, flush = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_result = 0, in_store_data = 0;
  logic [4:0]  in_op = 0, in_wb_addr = 0;
  logic        in_ready, out_valid, out_zero, out_wb_en, out_mem_wr, exc_valid;
  logic [31:0] out_pc, out_result, out_store_data, exc_epc;
  logic [4:0]  out_wb_addr, exc_code;
  always #5 clk = ~clk;
  ex_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_result(in_result),
    .in_zero(in_zero), .in_overflow(in_overflow), .in_op(in_op), .in_wb_en(in_wb_en),
    .in_wb_addr(in_wb_addr), .in_mem_wr(in_mem_wr), .in_store_data(in_store_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_pc(out_pc),
    .out_result(out_result), .out_zero(out_zero), .out_wb_en(out_wb_en),
    .out_wb_addr(out_wb_addr), .out_mem_wr(out_mem_wr), .out_store_data(out_store_data),
    .out_ready(out_ready), .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_code(exc_code)
  );
  entry_t      exp_q[$];
  logic [31:0] exc_q[$];
  int          checks = 0, failures = 0, occ = 0;
  bit          trap_mode = 0, last_acc = 0;
  logic [31:0] last_epc = 0;
  logic [4:0]  last_code = 0;
  entry_t      mon_g, mon_e;
  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", n, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        mon_g = '{pc: out_pc, result: out_result, zero: out_zero, wb_en: out_wb_en,
                  wb_addr: out_wb_addr, mem_wr: out_mem_wr, store_data: out_store_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_unexpected got=%h expected=none", mon_g);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_g !== mon_e) begin
            failures++;
            $display("FAIL out_entry got=%h expected=%h", mon_g, mon_e);
          end
        end
      end
      if (exc_valid) begin
        checks++;
        if (exc_q.size() == 0) begin
          failures++;
          $display("FAIL exc_unexpected got_epc=%h expected=none", exc_epc);
        end else begin
          last_epc = exc_q.pop_front();
          last_code = 5'd12;
          if (exc_epc !== last_epc || exc_code !== last_code) begin
            failures++;
            $display("FAIL exc_report got=%h/%0d expected=%h/%0d", exc_epc, exc_code, last_epc, last_code);
          end
        end
      end else begin
        checks++;
        if (exc_epc !== last_epc || exc_code !== last_code) begin
          failures++;
          $display("FAIL exc_hold got=%h/%0d expected=%h/%0d", exc_epc, exc_code, last_epc, last_code);
        end
      end
    end
  end
  task automatic step();
    bit     rdy, tr;
    entry_t e;
    @(negedge clk);
    #1;
    rdy = trap_mode || (SKID ? occ < 2 : (occ == 0 || out_ready));
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, occ > 0);
    last_acc = in_valid && in_ready;
    if (flush) begin
      exp_q.delete();
      occ = 0;
      trap_mode = 0;
    end else begin
      if (out_valid && out_ready) occ--;
      if (last_acc && !trap_mode) begin
        tr = in_overflow && (in_op == 5'b10000 || in_op == 5'b10010);
        e = '{pc: in_pc, result: in_result, zero: in_zero, wb_en: in_wb_en && !tr,
              wb_addr: in_wb_addr, mem_wr: in_mem_wr && !tr, store_data: in_store_data};
        exp_q.push_back(e);
        occ++;
        if (tr) begin
          exc_q.push_back(in_pc);
          trap_mode = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drive(bit v, logic [31:0] pc, logic [31:0] res, logic [4:0] op, bit ov,
                       bit wb, bit mw, bit fl, bit ordy);
    in_valid = v; in_pc = pc; in_result = res; in_op = op; in_overflow = ov;
    in_wb_en = wb; in_mem_wr = mw; flush = fl; out_ready = ordy;
    in_zero = 1'($urandom); in_wb_addr = 5'($urandom); in_store_data = $urandom;
    step();
  endtask
  initial begin
    int i;
    logic [4:0] op;
    int r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_exc_epc", exc_epc, 0);
    rst = 0;
    drive(1, 32'h100, 32'h5, 5'b10001, 0, 1, 0, 0, 1);
    chk("basic_valid", out_valid, 1);
    chk("basic_result", out_result, 32'h5);
    chk("basic_wb_en", out_wb_en, 1);
    drive(1, 32'h400, 32'h7fff_ffff, 5'b10000, 1, 1, 1, 0, 1);
    chk("trap_exc_valid", exc_valid, 1);
    chk("trap_epc", exc_epc, 32'h400);
    chk("trap_code", exc_code, 12);
    chk("trap_wb_en", out_wb_en, 0);
    chk("trap_mem_wr", out_mem_wr, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("trap_pulse_end", exc_valid, 0);
    drive(1, 32'h500, 32'h9, 5'b10011, 1, 1, 0, 0, 1);
    chk("ov_other_exc", exc_valid, 0);
    chk("ov_other_wb_en", out_wb_en, 1);
    drive(1, 32'h600, 32'h1, 5'b10010, 1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) drive(1, 32'h700 + k, k, 5'b10001, 0, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 32'h800, 32'h88, 5'b10001, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    i = 0;
    for (int t = 0; t < 16; t++) begin
      if (i < 3) drive(1, 32'ha00 + i, 32'hab0 + i, 5'b10001, 0, 1, 0, 0, t >= 3);
      else drive(0, 0, 0, 0, 0, 0, 0, 0, t >= 3);
      if (i < 3 && last_acc) i++;
    end
    chk("abc_all_accepted", i, 3);
    drive(1, 32'hb00, 32'h1, 5'b10001, 0, 1, 0, 0, 0);
    drive(1, 32'hb04, 32'h2, 5'b10000, 1, 1, 0, 0, 0);
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_exc_valid", exc_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    exp_q.delete(); exc_q.delete();
    occ = 0; trap_mode = 0; last_epc = 0; last_code = 0;
    @(posedge clk);
    #1;
    chk("midrst_hold_exc", exc_valid, 0);
    rst = 0;
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(5);
      op = (r < 4) ? 5'(16 + r) : 5'($urandom);
      drive($urandom_range(9) < 7, $urandom, $urandom, op, $urandom_range(3) == 0,
            1'($urandom), 1'($urandom), $urandom_range(19) == 0, $urandom_range(3) != 0);
    end
    for (int t = 0; t < 20 && (exp_q.size() != 0 || occ != 0); t++) drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain_left", exp_q.size(), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("exc_left", exc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
